// File: rtl/pwm_multi_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;

  localparam int PWM_DEFAULT_PERIOD = 1200;
  localparam int PWM_MIN_PERIOD     = 2;

endpackage

// File: rtl/pwm_multi_if.sv
// Control/output bundle of pwm_multi. There is no valid/ready handshake: every
// *_load strobe is a single-cycle qualified write that is never back-pressured.
interface pwm_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 11
);
  logic [WIDTH-1:0]          period_in;
  logic                      period_load;
  logic                      center_in;
  logic [CHANNELS*WIDTH-1:0] duty_in;
  logic [CHANNELS-1:0]       duty_load;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_start;

  modport master (
    output period_in, period_load, center_in, duty_in, duty_load,
    input  pwm_out, period_start
  );

  modport slave (
    input  period_in, period_load, center_in, duty_in, duty_load,
    output pwm_out, period_start
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// One PWM channel: double-buffered duty and the registered compare output.
module pwm_channel #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             load_i,
  input  logic             boundary_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic             pwm_q, pwm_d;

  // Active copies the post-write shadow so a load in the boundary cycle lands now.
  always_comb begin
    duty_sh_d  = load_i ? duty_i : duty_sh_q;
    duty_act_d = boundary_i ? duty_sh_d : duty_act_q;
    pwm_d      = (cnt_i < duty_act_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned period counter with
// double-buffered period/mode, broadcasting cnt and boundary to the channels.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 11,
  parameter int DEFAULT_PERIOD = PWM_DEFAULT_PERIOD
) (
  input  logic        clk,
  input  logic        rst,
  pwm_multi_if.slave  bus
);

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(PWM_MIN_PERIOD);
  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);

  logic [WIDTH-1:0] per_sh_q, per_sh_d;
  logic [WIDTH-1:0] per_act_q, per_act_d;
  pwm_mode_t        mode_sh_q, mode_sh_d;
  pwm_mode_t        mode_act_q, mode_act_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             start_q, start_d;

  logic [WIDTH-1:0] pe;
  logic [WIDTH-1:0] pe_last;
  logic             at_top;
  logic             boundary;
  logic [CHANNELS-1:0] pwm_w;

  always_comb begin
    pe       = (per_act_q < MIN_P) ? MIN_P : per_act_q;
    pe_last  = pe - WIDTH'(1);
    at_top   = (cnt_q == pe_last);
    boundary = (mode_act_q == PWM_EDGE) ? at_top : ((cnt_q == '0) && dir_q);
  end

  // Shadow is written every cycle; active follows the post-write shadow at the boundary.
  always_comb begin
    per_sh_d   = bus.period_load ? bus.period_in : per_sh_q;
    mode_sh_d  = bus.period_load ? (bus.center_in ? PWM_CENTER : PWM_EDGE) : mode_sh_q;
    per_act_d  = boundary ? per_sh_d  : per_act_q;
    mode_act_d = boundary ? mode_sh_d : mode_act_q;
  end

  // Every boundary restarts at cnt=0 counting up, which also covers mode changes.
  // In center mode the top endpoint is held one extra cycle while dir flips.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (boundary) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (mode_act_q == PWM_EDGE) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (!dir_q) begin
      if (at_top) begin
        dir_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_q - WIDTH'(1);
    end
    start_d = (cnt_q == '0) && !dir_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_sh_q   <= DEF_P;
      per_act_q  <= DEF_P;
      mode_sh_q  <= PWM_EDGE;
      mode_act_q <= PWM_EDGE;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      per_sh_q   <= per_sh_d;
      per_act_q  <= per_act_d;
      mode_sh_q  <= mode_sh_d;
      mode_act_q <= mode_act_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      start_q    <= start_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .duty_i    (bus.duty_in[k*WIDTH +: WIDTH]),
      .load_i    (bus.duty_load[k]),
      .boundary_i(boundary),
      .cnt_i     (cnt_q),
      .pwm_o     (pwm_w[k])
    );
  end

  assign bus.pwm_out      = pwm_w;
  assign bus.period_start = start_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: stimulus pushes the expected output of each
// cycle into a queue, a negedge monitor pops and compares.
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int W  = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_multi_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  pwm_multi #(
    .CHANNELS      (CH),
    .WIDTH         (W),
    .DEFAULT_PERIOD(1200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  // entry: {care, period_start, pwm_out[3:0]}
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Expected active and pending (shadow) configuration.
  int epe;
  bit ecenter;
  int ed[CH];
  int pend_p;
  bit pend_center;
  int pend_d[CH];
  int pos;

  function automatic logic [5:0] model_out();
    logic [3:0] b;
    int d;
    b = '0;
    for (int k = 0; k < CH; k++) begin
      d = (ed[k] > epe) ? epe : ed[k];
      if (!ecenter) b[k] = (pos < d);
      else          b[k] = (pos < d) || (pos >= 2*epe - d);
    end
    return {1'b1, (pos == 0), b};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [5:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.period_load = 1'b0;
    bus.duty_load   = '0;
  endtask

  task automatic tick_model();
    int len;
    tick(model_out());
    len = ecenter ? 2*epe : epe;
    pos++;
    if (pos >= len) begin
      pos     = 0;
      epe     = (pend_p < 2) ? 2 : pend_p;
      ecenter = pend_center;
      ed      = pend_d;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick_model();
  endtask

  task automatic run_to_wrap();
    do tick_model(); while (pos != 0);
  endtask

  task automatic load_duty(input int ch, input int v);
    bus.duty_in[ch*W +: W] = W'(v);
    bus.duty_load[ch]      = 1'b1;
    pend_d[ch]             = v;
  endtask

  task automatic load_period(input int p, input bit c);
    bus.period_in   = W'(p);
    bus.center_in   = c;
    bus.period_load = 1'b1;
    pend_p          = p;
    pend_center     = c;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick(6'b100000);
    epe = 1200; ecenter = 1'b0; pos = 0;
    pend_p = 1200; pend_center = 1'b0;
    for (int k = 0; k < CH; k++) begin
      ed[k] = 0;
      pend_d[k] = 0;
    end
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [5:0] e;
    logic [4:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[5]) begin
          checks++;
          got = {bus.period_start, bus.pwm_out};
          if (got !== e[4:0]) begin
            errors++;
            if (errors <= 20)
              $display("FAIL out_cycle t=%0t got start=%b pwm=%b expected start=%b pwm=%b",
                       $time, got[4], got[3:0], e[4], e[3:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.period_in   = '0;
    bus.period_load = 1'b0;
    bus.center_in   = 1'b0;
    bus.duty_in     = '0;
    bus.duty_load   = '0;

    // Reset state, then default 1200-cycle edge period with duty[0]=300.
    do_reset(3);
    load_duty(0, 300);
    run(3600);

    // Duty[1] loaded mid-period at cnt=500, then a load in the boundary cycle.
    run(500);
    load_duty(1, 600);
    run_to_wrap();
    run(1200);
    run(1199);
    load_duty(1, 100);
    run(1);
    run(1200);

    // P=10 with duties 0, 1, 10, 10.
    run(3);
    load_period(10, 1'b0);
    load_duty(0, 0);
    load_duty(1, 1);
    load_duty(2, 10);
    load_duty(3, 10);
    run_to_wrap();
    run(30);

    // Center mode P=8, duty 3 on ch0, loaded mid-period.
    run(5);
    load_period(8, 1'b1);
    load_duty(0, 3);
    load_duty(1, 1);
    load_duty(2, 8);
    load_duty(3, 9);
    run_to_wrap();
    run(48);

    // Mid-period switch back to edge mode waits for the boundary.
    run(7);
    load_period(5, 1'b0);
    run_to_wrap();
    run(10);

    // P=0 and P=1 behave as Pe=2.
    load_period(0, 1'b0);
    run_to_wrap();
    run(6);
    load_period(1, 1'b0);
    run_to_wrap();
    run(6);

    // Reset mid-period with pending shadow writes.
    load_period(20, 1'b0);
    load_duty(2, 4);
    run_to_wrap();
    run(7);
    load_duty(0, 7);
    load_period(50, 1'b0);
    run(2);
    do_reset(2);
    run(1205);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
